// File: rtl/conv_frame_feeder_if.sv
// Feeder-side bundle: 3-port frame RAM read side plus the conv_2d input side.
// Signal prefixes are relative to the feeder (o_ = driven by it, i_ = returned to it).
interface conv_frame_feeder_if #(
  parameter int DW     = 8,
  parameter int ADDR_W = 6
);
  logic              o_rd_en;
  logic [ADDR_W-1:0] o_addr1;
  logic [ADDR_W-1:0] o_addr2;
  logic [ADDR_W-1:0] o_addr3;
  logic [DW-1:0]     i_mem_data1;
  logic [DW-1:0]     i_mem_data2;
  logic [DW-1:0]     i_mem_data3;
  logic              o_load_knl;
  logic              o_data_valid;
  logic [DW-1:0]     o_data1;
  logic [DW-1:0]     o_data2;
  logic [DW-1:0]     o_data3;

  modport master (
    output o_rd_en, o_addr1, o_addr2, o_addr3,
    input  i_mem_data1, i_mem_data2, i_mem_data3,
    output o_load_knl, o_data_valid, o_data1, o_data2, o_data3
  );

  modport slave (
    input  o_rd_en, o_addr1, o_addr2, o_addr3,
    output i_mem_data1, i_mem_data2, i_mem_data3,
    input  o_load_knl, o_data_valid, o_data1, o_data2, o_data3
  );
endinterface

// File: rtl/conv_frame_feeder.sv
// Kernel preamble then 3-column strip streaming from a 3-port RAM into conv_2d; pixels
// leave 2 cycles after their address, o_done 4+N+FLUSH_CYCLES-1 cycles after start; no backpressure.
module conv_frame_feeder #(
  parameter int DW              = 8,
  parameter int IMG_H           = 12,
  parameter int IMG_W           = 3,
  parameter int VALID_ROW_START = 3,
  parameter int FLUSH_CYCLES    = 6,
  parameter int ADDR_W          = $clog2(IMG_H*IMG_W)
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [9*DW-1:0]      i_kernel,
  conv_frame_feeder_if.master  io_bus,
  output logic                 o_busy,
  output logic                 o_done
);

  generate
    if (IMG_H < 3 || IMG_W < 3 || FLUSH_CYCLES < 1) begin : g_bad_params
      $error("conv_frame_feeder: IMG_H and IMG_W must be >= 3 and FLUSH_CYCLES >= 1");
    end
  endgenerate

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam int FW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [RW-1:0]     ROW_LAST   = RW'(IMG_H - 1);
  localparam logic [CW-1:0]     COL_LAST   = CW'(IMG_W - 3);
  localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(IMG_W);
  localparam logic [FW-1:0]     FLUSH_LAST = FW'((FLUSH_CYCLES >= 2) ? FLUSH_CYCLES - 2 : 0);
  localparam bit                VRS_REACH  = (VALID_ROW_START < IMG_H);
  localparam logic [RW-1:0]     VRS_C      = RW'(VRS_REACH ? VALID_ROW_START : 0);

  typedef enum logic [2:0] {S_IDLE, S_KNL, S_STREAM, S_FLUSH, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_kcnt, w_kcnt_nxt;
  logic [FW-1:0]     r_fcnt, w_fcnt_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              w_latch, w_issue, w_load_knl;
  logic [DW-1:0]     w_kw1, w_kw2, w_kw3;
  logic [9*DW-1:0]   r_kernel;
  logic              r_rd_en;
  logic [RW-1:0]     r_row, r_row_b;
  logic [CW-1:0]     r_col;
  logic [ADDR_W-1:0] r_addr1, r_addr2, r_addr3, w_strip_base;
  logic              r_vld_b, w_row_ok;
  logic              r_load_knl, r_data_valid;
  logic [DW-1:0]     r_data1, r_data2, r_data3;

  always_ff @(posedge clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // DONE is the cycle before o_done is seen, so the FSM is back in IDLE while o_done is high.
  always_comb begin
    w_state_nxt = r_state;
    w_kcnt_nxt  = r_kcnt;
    w_fcnt_nxt  = r_fcnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_latch     = 1'b0;
    w_issue     = 1'b0;
    w_load_knl  = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) begin
        w_latch     = 1'b1;
        w_busy_nxt  = 1'b1;
        w_kcnt_nxt  = 2'd0;
        w_state_nxt = S_KNL;
      end
      S_KNL: begin
        w_load_knl = 1'b1;
        w_kcnt_nxt = r_kcnt + 2'd1;
        if (r_kcnt == 2'd1) w_issue = 1'b1;
        if (r_kcnt == 2'd2) w_state_nxt = S_STREAM;
      end
      S_STREAM: if (!r_rd_en) begin
        w_fcnt_nxt  = '0;
        w_state_nxt = (FLUSH_CYCLES <= 1) ? S_DONE : S_FLUSH;
      end
      S_FLUSH: begin
        if (r_fcnt == FLUSH_LAST) w_state_nxt = S_DONE;
        else                      w_fcnt_nxt  = r_fcnt + FW'(1);
      end
      S_DONE: begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_kw1 = r_kernel[2*DW +: DW];
    w_kw2 = r_kernel[1*DW +: DW];
    w_kw3 = r_kernel[0*DW +: DW];
    case (r_kcnt)
      2'd0: begin
        w_kw1 = r_kernel[8*DW +: DW];
        w_kw2 = r_kernel[7*DW +: DW];
        w_kw3 = r_kernel[6*DW +: DW];
      end
      2'd1: begin
        w_kw1 = r_kernel[5*DW +: DW];
        w_kw2 = r_kernel[4*DW +: DW];
        w_kw3 = r_kernel[3*DW +: DW];
      end
      default: ;
    endcase
    w_strip_base = ADDR_W'(r_col) + ADDR_W'(1);
    w_row_ok     = VRS_REACH && (r_row_b >= VRS_C);
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_kcnt       <= '0;
      r_fcnt       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_kernel     <= '0;
      r_rd_en      <= 1'b0;
      r_row        <= '0;
      r_col        <= '0;
      r_addr1      <= '0;
      r_addr2      <= '0;
      r_addr3      <= '0;
      r_vld_b      <= 1'b0;
      r_row_b      <= '0;
      r_load_knl   <= 1'b0;
      r_data_valid <= 1'b0;
      r_data1      <= '0;
      r_data2      <= '0;
      r_data3      <= '0;
    end else begin
      r_kcnt <= w_kcnt_nxt;
      r_fcnt <= w_fcnt_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      if (w_latch) r_kernel <= i_kernel;

      // Row base steps by IMG_W inside a strip and restarts at the next column on strip change.
      if (w_issue) begin
        r_rd_en <= 1'b1;
        r_row   <= '0;
        r_col   <= '0;
        r_addr1 <= ADDR_W'(0);
        r_addr2 <= ADDR_W'(1);
        r_addr3 <= ADDR_W'(2);
      end else if (r_rd_en) begin
        if (r_row == ROW_LAST) begin
          r_row <= '0;
          if (r_col == COL_LAST) begin
            r_rd_en <= 1'b0;
            r_col   <= '0;
            r_addr1 <= '0;
            r_addr2 <= '0;
            r_addr3 <= '0;
          end else begin
            r_col   <= r_col + CW'(1);
            r_addr1 <= w_strip_base;
            r_addr2 <= w_strip_base + ADDR_W'(1);
            r_addr3 <= w_strip_base + ADDR_W'(2);
          end
        end else begin
          r_row   <= r_row + RW'(1);
          r_addr1 <= r_addr1 + ROW_STEP;
          r_addr2 <= r_addr2 + ROW_STEP;
          r_addr3 <= r_addr3 + ROW_STEP;
        end
      end

      r_vld_b    <= r_rd_en;
      r_row_b    <= r_row;
      r_load_knl <= w_load_knl;
      if (r_vld_b) begin
        r_data1      <= io_bus.i_mem_data1;
        r_data2      <= io_bus.i_mem_data2;
        r_data3      <= io_bus.i_mem_data3;
        r_data_valid <= w_row_ok;
      end else if (w_load_knl) begin
        r_data1      <= w_kw1;
        r_data2      <= w_kw2;
        r_data3      <= w_kw3;
        r_data_valid <= 1'b0;
      end else begin
        r_data1      <= '0;
        r_data2      <= '0;
        r_data3      <= '0;
        r_data_valid <= 1'b0;
      end
    end
  end

  assign io_bus.o_rd_en      = r_rd_en;
  assign io_bus.o_addr1      = r_addr1;
  assign io_bus.o_addr2      = r_addr2;
  assign io_bus.o_addr3      = r_addr3;
  assign io_bus.o_load_knl   = r_load_knl;
  assign io_bus.o_data_valid = r_data_valid;
  assign io_bus.o_data1      = r_data1;
  assign io_bus.o_data2      = r_data2;
  assign io_bus.o_data3      = r_data3;
  assign o_busy              = r_busy;
  assign o_done              = r_done;

endmodule

// File: tb/tb_conv_frame_feeder.sv
// Directed bench: dut_a uses defaults (H=12, W=3, RAM row r holds r+1); dut_b is H=4, W=5
// with RAM word = its address. Cycle c is sampled 1 time unit after the c-th edge following start.
module tb_conv_frame_feeder;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            a_rst, a_start, a_busy, a_done;
  logic            b_rst, b_start, b_busy, b_done;
  logic [9*DW-1:0] a_kernel, b_kernel;

  conv_frame_feeder_if #(.DW(DW), .ADDR_W(6)) bus_a();
  conv_frame_feeder_if #(.DW(DW), .ADDR_W(5)) bus_b();

  conv_frame_feeder #(.DW(DW), .IMG_H(12), .IMG_W(3), .VALID_ROW_START(3),
                      .FLUSH_CYCLES(6), .ADDR_W(6)) dut_a (
    .clk(clk), .i_rst(a_rst), .i_start(a_start), .i_kernel(a_kernel),
    .io_bus(bus_a), .o_busy(a_busy), .o_done(a_done));

  conv_frame_feeder #(.DW(DW), .IMG_H(4), .IMG_W(5), .VALID_ROW_START(3),
                      .FLUSH_CYCLES(6), .ADDR_W(5)) dut_b (
    .clk(clk), .i_rst(b_rst), .i_start(b_start), .i_kernel(b_kernel),
    .io_bus(bus_b), .o_busy(b_busy), .o_done(b_done));

  always @(posedge clk) begin
    if (bus_a.o_rd_en) begin
      bus_a.i_mem_data1 <= 8'(bus_a.o_addr1 / 6'd3 + 6'd1);
      bus_a.i_mem_data2 <= 8'(bus_a.o_addr2 / 6'd3 + 6'd1);
      bus_a.i_mem_data3 <= 8'(bus_a.o_addr3 / 6'd3 + 6'd1);
    end
    if (bus_b.o_rd_en) begin
      bus_b.i_mem_data1 <= 8'(bus_b.o_addr1);
      bus_b.i_mem_data2 <= 8'(bus_b.o_addr2);
      bus_b.i_mem_data3 <= 8'(bus_b.o_addr3);
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  logic       cap_load[64], cap_vld[64], cap_rden[64], cap_busy[64], cap_done[64];
  logic [7:0] cap_d1[64], cap_d2[64], cap_d3[64];
  logic [5:0] cap_a1[64], cap_a2[64], cap_a3[64];

  localparam logic [71:0] K_MID = 72'h00_00_00_00_7F_00_00_00_00;
  localparam logic [71:0] K_SEQ = 72'h11_22_33_44_55_66_77_88_99;
  localparam logic [71:0] K_ALT = 72'hFF_FF_FF_FF_FF_FF_FF_FF_FF;
  localparam logic [71:0] K_NEG = 72'hFF_00_00_00_00_00_00_00_80;

  // Starts a frame on edge 0 and records cycles 0..ncyc-1. The kernel input switches to k_alt
  // after edge 0; start stays high through cycle hold_until; reset is high for cycle rst_at only.
  task automatic capture(input bit sel_b, input logic [71:0] k, input logic [71:0] k_alt,
                         input int ncyc, input int hold_until, input int rst_at);
    @(negedge clk);
    if (sel_b) begin b_start = 1'b1; b_kernel = k; end
    else       begin a_start = 1'b1; a_kernel = k; end
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      cap_load[c] = sel_b ? bus_b.o_load_knl   : bus_a.o_load_knl;
      cap_vld[c]  = sel_b ? bus_b.o_data_valid : bus_a.o_data_valid;
      cap_rden[c] = sel_b ? bus_b.o_rd_en      : bus_a.o_rd_en;
      cap_busy[c] = sel_b ? b_busy             : a_busy;
      cap_done[c] = sel_b ? b_done             : a_done;
      cap_d1[c]   = sel_b ? bus_b.o_data1      : bus_a.o_data1;
      cap_d2[c]   = sel_b ? bus_b.o_data2      : bus_a.o_data2;
      cap_d3[c]   = sel_b ? bus_b.o_data3      : bus_a.o_data3;
      cap_a1[c]   = sel_b ? {1'b0, bus_b.o_addr1} : bus_a.o_addr1;
      cap_a2[c]   = sel_b ? {1'b0, bus_b.o_addr2} : bus_a.o_addr2;
      cap_a3[c]   = sel_b ? {1'b0, bus_b.o_addr3} : bus_a.o_addr3;
      if (c == 0) begin
        if (sel_b) b_kernel = k_alt; else a_kernel = k_alt;
      end
      if (c == hold_until) begin
        if (sel_b) b_start = 1'b0; else a_start = 1'b0;
      end
      if (c == rst_at) a_rst = 1'b1;
      else if (c == rst_at + 1) a_rst = 1'b0;
    end
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1; a_start = 1'b0; b_start = 1'b0;
    a_kernel = '0; b_kernel = '0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({a_busy, a_done, bus_a.o_rd_en, bus_a.o_load_knl, bus_a.o_data_valid} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl_a got=%b exp=00000",
               {a_busy, a_done, bus_a.o_rd_en, bus_a.o_load_knl, bus_a.o_data_valid});
    end
    n_chk++;
    if ({bus_a.o_addr1, bus_a.o_addr2, bus_a.o_addr3, bus_a.o_data1, bus_a.o_data2, bus_a.o_data3} !== 42'b0) begin
      n_fail++;
      $display("FAIL reset_bus_a got=%h exp=0",
               {bus_a.o_addr1, bus_a.o_addr2, bus_a.o_addr3, bus_a.o_data1, bus_a.o_data2, bus_a.o_data3});
    end
    n_chk++;
    if ({b_busy, b_done, bus_b.o_rd_en, bus_b.o_load_knl, bus_b.o_data_valid} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl_b got=%b exp=00000",
               {b_busy, b_done, bus_b.o_rd_en, bus_b.o_load_knl, bus_b.o_data_valid});
    end
    n_chk++;
    if ({bus_b.o_addr1, bus_b.o_data1, bus_b.o_data2, bus_b.o_data3} !== 29'b0) begin
      n_fail++;
      $display("FAIL reset_bus_b got=%h exp=0",
               {bus_b.o_addr1, bus_b.o_data1, bus_b.o_data2, bus_b.o_data3});
    end
    @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0;
  endtask

  task automatic test_kernel_load();
    logic [7:0] exp_d2[4];
    exp_d2 = '{8'h00, 8'h00, 8'h7F, 8'h00};
    capture(1'b0, K_MID, K_MID, 22, 0, -1);
    for (int c = 0; c < 4; c++) begin
      n_chk++;
      if (cap_load[c] !== (c >= 1)) begin
        n_fail++; $display("FAIL knl_load cyc=%0d got=%b exp=%b", c, cap_load[c], (c >= 1));
      end
      n_chk++;
      if ({cap_vld[c], cap_d1[c], cap_d2[c], cap_d3[c]} !== {1'b0, 8'h00, exp_d2[c], 8'h00}) begin
        n_fail++;
        $display("FAIL knl_data cyc=%0d got=%b/%h/%h/%h exp=0/00/%h/00",
                 c, cap_vld[c], cap_d1[c], cap_d2[c], cap_d3[c], exp_d2[c]);
      end
    end
  endtask

  task automatic test_stream_default();
    capture(1'b0, K_MID, K_MID, 26, 0, -1);
    for (int c = 4; c < 26; c++) begin
      logic [7:0] e;
      e = (c <= 15) ? 8'(c - 3) : 8'h00;
      n_chk++;
      if ({cap_d1[c], cap_d2[c], cap_d3[c]} !== {e, e, e}) begin
        n_fail++;
        $display("FAIL stream_data cyc=%0d got=%h/%h/%h exp=%h", c, cap_d1[c], cap_d2[c], cap_d3[c], e);
      end
      n_chk++;
      if (cap_vld[c] !== (c >= 7 && c <= 15) || cap_load[c] !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_valid cyc=%0d got=%b load=%b exp=%b", c, cap_vld[c], cap_load[c], (c >= 7 && c <= 15));
      end
    end
    for (int c = 0; c < 26; c++) begin
      n_chk++;
      if (cap_done[c] !== (c == 21) || cap_busy[c] !== (c <= 20)) begin
        n_fail++;
        $display("FAIL stream_done_busy cyc=%0d got=%b/%b exp=%b/%b", c, cap_done[c], cap_busy[c], (c == 21), (c <= 20));
      end
      n_chk++;
      if (cap_rden[c] !== (c >= 2 && c <= 13) ||
          cap_a1[c] !== ((c >= 2 && c <= 13) ? 6'((c - 2) * 3) : 6'd0)) begin
        n_fail++;
        $display("FAIL stream_addr cyc=%0d got=%b/%0d", c, cap_rden[c], cap_a1[c]);
      end
    end
  endtask

  task automatic test_addr_seq();
    int exp_a[12];
    exp_a = '{0, 5, 10, 15, 1, 6, 11, 16, 2, 7, 12, 17};
    capture(1'b1, K_MID, K_MID, 24, 0, -1);
    for (int i = 0; i < 12; i++) begin
      n_chk++;
      if ({cap_rden[2+i], cap_a1[2+i], cap_a2[2+i], cap_a3[2+i]} !==
          {1'b1, 6'(exp_a[i]), 6'(exp_a[i] + 1), 6'(exp_a[i] + 2)}) begin
        n_fail++;
        $display("FAIL addr_seq i=%0d got=%b/%0d/%0d/%0d exp=1/%0d/+1/+2",
                 i, cap_rden[2+i], cap_a1[2+i], cap_a2[2+i], cap_a3[2+i], exp_a[i]);
      end
      n_chk++;
      if ({cap_vld[4+i], cap_d1[4+i], cap_d2[4+i], cap_d3[4+i]} !==
          {(i % 4) == 3, 8'(exp_a[i]), 8'(exp_a[i] + 1), 8'(exp_a[i] + 2)}) begin
        n_fail++;
        $display("FAIL strip_data i=%0d got=%b/%h/%h/%h exp=%b/%h", i, cap_vld[4+i],
                 cap_d1[4+i], cap_d2[4+i], cap_d3[4+i], (i % 4) == 3, 8'(exp_a[i]));
      end
    end
    n_chk++;
    if ({cap_rden[14], cap_a1[14], cap_a3[14]} !== 13'b0) begin
      n_fail++; $display("FAIL addr_idle got=%b/%0d/%0d exp=0/0/0", cap_rden[14], cap_a1[14], cap_a3[14]);
    end
    for (int c = 0; c < 24; c++) begin
      n_chk++;
      if (cap_done[c] !== (c == 21)) begin
        n_fail++; $display("FAIL strip_done cyc=%0d got=%b exp=%b", c, cap_done[c], (c == 21));
      end
    end
  endtask

  task automatic test_start_held();
    capture(1'b0, K_SEQ, K_ALT, 46, 22, -1);
    n_chk++;
    if ({cap_d1[1], cap_d2[1], cap_d3[1], cap_d1[2], cap_d3[3]} !== 40'h11_22_33_44_99) begin
      n_fail++;
      $display("FAIL held_kernel got=%h/%h/%h/%h/%h exp=11/22/33/44/99",
               cap_d1[1], cap_d2[1], cap_d3[1], cap_d1[2], cap_d3[3]);
    end
    for (int c = 0; c < 46; c++) begin
      n_chk++;
      if (cap_done[c] !== (c == 21 || c == 43)) begin
        n_fail++; $display("FAIL held_done cyc=%0d got=%b exp=%b", c, cap_done[c], (c == 21 || c == 43));
      end
    end
    n_chk++;
    if ({cap_busy[20], cap_busy[21], cap_busy[22], cap_busy[43]} !== 4'b1010) begin
      n_fail++;
      $display("FAIL held_busy got=%b exp=1010", {cap_busy[20], cap_busy[21], cap_busy[22], cap_busy[43]});
    end
    n_chk++;
    if ({cap_load[22], cap_load[23], cap_d1[23]} !== {2'b01, 8'hFF}) begin
      n_fail++;
      $display("FAIL held_second_kernel got=%b/%b/%h exp=0/1/ff", cap_load[22], cap_load[23], cap_d1[23]);
    end
  endtask

  task automatic test_reset_midstream();
    capture(1'b0, K_MID, K_MID, 10, 0, 8);
    n_chk++;
    if ({cap_vld[8], cap_d1[8], cap_rden[8]} !== {1'b1, 8'h05, 1'b1}) begin
      n_fail++; $display("FAIL midrst_pre got=%b/%h/%b exp=1/05/1", cap_vld[8], cap_d1[8], cap_rden[8]);
    end
    n_chk++;
    if ({cap_busy[9], cap_done[9], cap_rden[9], cap_load[9], cap_vld[9]} !== 5'b0) begin
      n_fail++;
      $display("FAIL midrst_ctrl got=%b exp=00000",
               {cap_busy[9], cap_done[9], cap_rden[9], cap_load[9], cap_vld[9]});
    end
    n_chk++;
    if ({cap_a1[9], cap_a2[9], cap_a3[9], cap_d1[9], cap_d2[9], cap_d3[9]} !== 42'b0) begin
      n_fail++;
      $display("FAIL midrst_bus got=%h exp=0", {cap_a1[9], cap_a2[9], cap_a3[9], cap_d1[9], cap_d2[9], cap_d3[9]});
    end
    capture(1'b0, K_MID, K_MID, 22, 0, -1);
    n_chk++;
    if ({cap_rden[2], cap_a1[2], cap_load[1], cap_d2[2]} !== {1'b1, 6'd0, 1'b1, 8'h7F}) begin
      n_fail++;
      $display("FAIL restart_head got=%b/%0d/%b/%h exp=1/0/1/7f", cap_rden[2], cap_a1[2], cap_load[1], cap_d2[2]);
    end
    n_chk++;
    if ({cap_d1[4], cap_d2[5], cap_vld[6], cap_vld[7], cap_d3[7]} !== {8'h01, 8'h02, 2'b01, 8'h04}) begin
      n_fail++;
      $display("FAIL restart_rows got=%h/%h/%b/%b/%h exp=01/02/0/1/04",
               cap_d1[4], cap_d2[5], cap_vld[6], cap_vld[7], cap_d3[7]);
    end
    n_chk++;
    if ({cap_done[20], cap_done[21]} !== 2'b01) begin
      n_fail++; $display("FAIL restart_done got=%b exp=01", {cap_done[20], cap_done[21]});
    end
  endtask

  task automatic test_negative_kernel();
    capture(1'b0, K_NEG, K_NEG, 22, 0, -1);
    n_chk++;
    if ({cap_d1[1], cap_d2[1], cap_d3[1]} !== 24'hFF_00_00) begin
      n_fail++; $display("FAIL neg_k9 got=%h/%h/%h exp=ff/00/00", cap_d1[1], cap_d2[1], cap_d3[1]);
    end
    n_chk++;
    if ({cap_d1[3], cap_d2[3], cap_d3[3]} !== 24'h00_00_80) begin
      n_fail++; $display("FAIL neg_k1 got=%h/%h/%h exp=00/00/80", cap_d1[3], cap_d2[3], cap_d3[3]);
    end
  endtask

  initial begin
    test_reset();
    test_kernel_load();
    test_stream_default();
    test_addr_seq();
    test_start_held();
    test_reset_midstream();
    test_negative_kernel();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
